// File: rtl/codeword_packer.sv
// codeword_packer
//   Packs code words, received one character per beat on a valid/ready stream,
//   into a WORD_W-bit format for the decipherability checker: CHAR_W-bit
//   characters with the first character in the lowest bits, a single stop bit
//   directly above the last character, zeros above the stop bit. Malformed
//   words (illegal character code or too many characters) are dropped with a
//   one-cycle err_o pulse.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-high
//   in_valid_i   in_char_i/in_last_i valid
//   in_ready_o   packer accepts a character this cycle
//   in_char_i    character code
//   in_last_i    this character ends the word
//   out_valid_o  out_word_o/out_len_o valid
//   out_ready_i  consumer takes the word this cycle
//   out_word_o   packed word
//   out_len_o    character count of out_word_o (1..MAX_CHARS)
//   err_o        one-cycle pulse: current word rejected
module codeword_packer #(
  parameter int unsigned CHAR_W    = 3,
  parameter int unsigned MAX_CHARS = 5,
  parameter int unsigned WORD_W    = 16,  // must equal MAX_CHARS*CHAR_W+1
  parameter int unsigned MAX_CODE  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CHAR_W-1:0] in_char_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_word_o,
  output logic [2:0]        out_len_o,
  output logic              err_o
);

  typedef enum logic [1:0] {StAcc, StHold, StDrain} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [2:0]        len_q, len_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              accept;
  logic              bad_beat;

  // Decoded from state only, so in_ready_o never depends on in_valid_i.
  assign in_ready_o = (state_q == StAcc) || (state_q == StDrain);
  assign accept     = in_valid_i && in_ready_o;
  assign bad_beat   = (in_char_i > CHAR_W'(MAX_CODE)) || (cnt_q == 3'(MAX_CHARS));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    len_d   = len_q;
    valid_d = valid_q;
    err_d   = 1'b0;

    case (state_q)
      StAcc: begin
        if (accept) begin
          if (bad_beat) begin
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            // Swallow the rest of the word unless this beat already ended it.
            state_d = in_last_i ? StAcc : StDrain;
          end else if (!in_last_i) begin
            for (int i = 0; i < int'(MAX_CHARS); i++) begin
              if (cnt_q == 3'(i)) acc_d[i*CHAR_W +: CHAR_W] = in_char_i;
            end
            cnt_d = cnt_q + 3'd1;
          end else begin
            // cnt_q <= MAX_CHARS-1 here, so the stop bit lands within the word.
            word_d = acc_q;
            for (int i = 0; i < int'(MAX_CHARS); i++) begin
              if (cnt_q == 3'(i)) begin
                word_d[i*CHAR_W +: CHAR_W] = in_char_i;
                word_d[(i+1)*CHAR_W]       = 1'b1;
              end
            end
            len_d   = cnt_q + 3'd1;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StHold;
          end
        end
      end

      StHold: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          state_d = StAcc;
        end
      end

      StDrain: begin
        if (accept && in_last_i) state_d = StAcc;
      end

      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_word_o  = word_q;
  assign out_len_o   = len_q;
  assign err_o       = err_q;

endmodule
